fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register; feeds decode.

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
//   Issues word-aligned reads to a synchronous instruction memory with a
//   fixed 1-cycle read latency. During a stall, a 1-entry skid buffer catches
//   the response that is already in flight. A flush redirects fetch to
//   br_target in the same cycle and squashes the wrong-path instruction.
// Optional feature macro: FETCH_PERF_EN (stall/flush performance counters;
//   when undefined the perf ports are present and read as zero).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   load_stall         hold IF/ID, throttle fetch
//   flush, br_target   redirect fetch, squash IF/ID
//   imem_req/addr      read request and address (combinational)
//   imem_rdata         read data, valid one cycle after the request
//   id_valid/pc/instr  IF/ID register contents presented to decode
//   perf_stall_cycles  stall cycles not overridden by flush
//   perf_flush_count   flush cycles
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_stall,
  input  logic            flush,
  input  logic [XLEN-1:0] br_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flush_count
);

  localparam int unsigned ILEN = 32;

  logic [XLEN-1:0] pc_q;
  logic            inflight_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic            skid_valid_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [ILEN-1:0] skid_instr_q;

  // Request rule: during a stall only request if the skid can absorb the reply.
  assign imem_req  = rst_n & (flush | ~load_stall | (~skid_valid_q & ~inflight_q));
  assign imem_addr = flush ? br_target : pc_q;

  // Fetch PC and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= imem_req;
      if (imem_req) begin
        inflight_pc_q <= imem_addr;
      end
      if (flush) begin
        pc_q <= br_target + XLEN'(4);
      end else if (imem_req) begin
        pc_q <= pc_q + XLEN'(4);
      end
    end
  end

  // Skid buffer and IF/ID register; flush > load_stall > normal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_instr     <= NOP_INSTR;
    end else if (flush) begin
      skid_valid_q <= 1'b0;
      id_valid     <= 1'b0;
      id_instr     <= NOP_INSTR;
    end else if (load_stall) begin
      if (inflight_q) begin
        skid_valid_q <= 1'b1;
        skid_pc_q    <= inflight_pc_q;
        skid_instr_q <= imem_rdata;
      end
    end else if (skid_valid_q) begin
      // Drain the older skid entry first to keep program order.
      id_valid <= 1'b1;
      id_pc    <= skid_pc_q;
      id_instr <= skid_instr_q;
      if (inflight_q) begin
        skid_pc_q    <= inflight_pc_q;
        skid_instr_q <= imem_rdata;
      end else begin
        skid_valid_q <= 1'b0;
      end
    end else if (inflight_q) begin
      id_valid <= 1'b1;
      id_pc    <= inflight_pc_q;
      id_instr <= imem_rdata;
    end else begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Free-running counters, wrap at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_stall && !flush) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_count  = flush_cnt_q;
`else
  assign perf_stall_cycles = 32'h0;
  assign perf_flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
//   Memory model returns {16'hC0DE, addr[15:0]} one cycle after a request.
//   Inputs are driven at the falling edge; outputs are checked 1 time unit later.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_stall;
  logic        flush;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_stall        (load_stall),
    .flush             (flush),
    .br_target         (br_target),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .id_valid          (id_valid),
    .id_pc             (id_pc),
    .id_instr          (id_instr),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  // Synchronous instruction memory, 1-cycle latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= instr_of(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic stall, input logic fl, input logic [31:0] tgt);
    @(negedge clk);
    load_stall = stall;
    flush      = fl;
    br_target  = tgt;
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, 32'(id_valid), 32'd1);
    check({tag, ".pc"}, id_pc, pc);
    check({tag, ".instr"}, id_instr, instr_of(pc));
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, 32'(id_valid), 32'd0);
    check({tag, ".instr"}, id_instr, 32'h0000_0013);
  endtask

  logic [31:0] exp_stall;
  logic [31:0] exp_flush;

  initial begin
    rst_n = 1'b0; load_stall = 1'b0; flush = 1'b0; br_target = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.req", 32'(imem_req), 32'd0);
    check("rst.pc", id_pc, 32'h0);
    check_bubble("rst");
    check("rst.perf_stall", perf_stall_cycles, 32'h0);
    check("rst.perf_flush", perf_flush_count, 32'h0);

    // Streaming fetch from RESET_PC.
    @(negedge clk); rst_n = 1'b1; #1;
    check("c0.addr", imem_addr, 32'h0);
    check("c0.req", 32'(imem_req), 32'd1);
    cyc(1'b0, 1'b0, 32'h0);
    check("c1.addr", imem_addr, 32'h4);
    check("c1.valid", 32'(id_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'h0);
    check("c2.addr", imem_addr, 32'h8);
    check_id("c2", 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    check("c3.addr", imem_addr, 32'hC);
    check_id("c3", 32'h4);

    // Three-cycle stall with a response in flight: it lands in the skid.
    cyc(1'b1, 1'b0, 32'h0);
    check("c4.req", 32'(imem_req), 32'd0);
    check_id("c4", 32'h8);
    cyc(1'b1, 1'b0, 32'h0);
    check("c5.req", 32'(imem_req), 32'd0);
    check_id("c5", 32'h8);
    cyc(1'b1, 1'b0, 32'h0);
    check("c6.req", 32'(imem_req), 32'd0);
    check_id("c6", 32'h8);
    cyc(1'b0, 1'b0, 32'h0);
    check("c7.req", 32'(imem_req), 32'd1);
    check("c7.addr", imem_addr, 32'h10);
    check_id("c7", 32'h8);
    cyc(1'b0, 1'b0, 32'h0);
    check("c8.addr", imem_addr, 32'h14);
    check_id("c8", 32'hC);

    // Flush to 0x100 while 0x14 is in flight.
    cyc(1'b0, 1'b1, 32'h100);
    check("c9.addr", imem_addr, 32'h100);
    check("c9.req", 32'(imem_req), 32'd1);
    check_id("c9", 32'h10);
    cyc(1'b0, 1'b0, 32'h0);
    check("c10.addr", imem_addr, 32'h104);
    check_bubble("c10");

    // Fill the skid, then flush and stall together.
    cyc(1'b1, 1'b0, 32'h0);
    check("c11.req", 32'(imem_req), 32'd0);
    check_id("c11", 32'h100);
    cyc(1'b1, 1'b1, 32'h200);
    check("c12.req", 32'(imem_req), 32'd1);
    check("c12.addr", imem_addr, 32'h200);
    check_id("c12", 32'h100);
    cyc(1'b0, 1'b0, 32'h0);
    check("c13.addr", imem_addr, 32'h204);
    check_bubble("c13");

    // One more stall so the skid path delivers 0x204 after 0x200.
    cyc(1'b1, 1'b0, 32'h0);
    check("c14.req", 32'(imem_req), 32'd0);
    check_id("c14", 32'h200);
    cyc(1'b0, 1'b0, 32'h0);
    check("c15.addr", imem_addr, 32'h208);
    check_id("c15", 32'h200);
    cyc(1'b0, 1'b0, 32'h0);
    check_id("c16", 32'h204);
`ifdef FETCH_PERF_EN
    exp_stall = 32'd5;
    exp_flush = 32'd2;
`else
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif
    check("c16.perf_stall", perf_stall_cycles, exp_stall);
    check("c16.perf_flush", perf_flush_count, exp_flush);
    cyc(1'b0, 1'b0, 32'h0);
    check_id("c17", 32'h208);

    // Asynchronous reset mid-stream.
    #2 rst_n = 1'b0;
    #1;
    check("arst.req", 32'(imem_req), 32'd0);
    check("arst.pc", id_pc, 32'h0);
    check_bubble("arst");
    check("arst.perf_stall", perf_stall_cycles, 32'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("r0.addr", imem_addr, 32'h0);
    check("r0.req", 32'(imem_req), 32'd1);
    check("r0.valid", 32'(id_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'h0);
    check("r1.valid", 32'(id_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'h0);
    check_id("r2", 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    check_id("r3", 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
